bp_fe_bp_bimodal_ctrl: RTL and testbench

BP_FE_BP_BIMODAL_CTRL -- requirements
Module: bp_fe_bp_bimodal_ctrl

---
 rtl/bp_fe_bp_bimodal_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bp_fe_bp_bimodal_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bp_bimodal_ctrl.sv
// Bimodal branch predictor front-end controller.
// Tracks in-flight branches in a small circular queue. Each fetch looks up
// the predictor and captures its answer one cycle later. Each in-order
// resolve pops the oldest entry and sends an update (index, correct) back
// to the predictor one cycle after the resolve.
//
// Handshakes: a fetch transfers when fetch_v_i && fetch_ready_o. A resolve
// transfers when resolve_v_i && resolve_ready_o && !flush_i. Both ready
// signals depend only on registered state, so a valid may wait on ready
// without a combinational loop. pred_v_o and w_v_o are single-cycle pulses
// with no backpressure.
//
// queue_depth_p must be a power of two and at least 2. The pointers rely on
// natural binary wrap. A depth of 1 would let the slot being captured alias
// the slot being allocated.
module bp_fe_bp_bimodal_ctrl #(
   parameter int vaddr_width_p   = 39,
   parameter int bht_idx_width_p = 9,
   parameter int pc_shift_p      = 2,
   parameter int queue_depth_p   = 4
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   // fetch lookup request
   input  logic                               fetch_v_i,
   input  logic [vaddr_width_p-1:0]           fetch_pc_i,
   output logic                               fetch_ready_o,
   // prediction returned to fetch
   output logic                               pred_v_o,
   output logic                               pred_taken_o,
   // in-order resolution of the oldest branch
   input  logic                               resolve_v_i,
   input  logic                               resolve_taken_i,
   output logic                               resolve_ready_o,
   // pipeline flush
   input  logic                               flush_i,
   // predictor read port
   output logic                               r_v_o,
   output logic [bht_idx_width_p-1:0]         idx_r_o,
   input  logic                               predict_i,
   // predictor update port
   output logic                               w_v_o,
   output logic [bht_idx_width_p-1:0]         idx_w_o,
   output logic                               correct_o,
   // occupancy
   output logic [$clog2(queue_depth_p):0]     count_o
);

   localparam int ptr_w_lp = $clog2(queue_depth_p);
   localparam int cnt_w_lp = ptr_w_lp + 1;
   localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(queue_depth_p);

   // queue pointers and occupancy
   logic [ptr_w_lp-1:0]        head_q, head_d;
   logic [ptr_w_lp-1:0]        tail_q, tail_d;
   logic [cnt_w_lp-1:0]        count_q, count_d;

   // per-entry storage: predictor index, captured prediction, capture flag
   logic [bht_idx_width_p-1:0] idx_mem_q [queue_depth_p];
   logic [bht_idx_width_p-1:0] idx_mem_d [queue_depth_p];
   logic [queue_depth_p-1:0]   pred_mem_q, pred_mem_d;
   logic [queue_depth_p-1:0]   cap_q, cap_d;

   // prediction pending from last cycle's accepted fetch
   logic                       pred_pend_q, pred_pend_d;
   logic [ptr_w_lp-1:0]        pred_slot_q, pred_slot_d;

   // registered update pulse to the predictor
   logic                       w_v_q, w_v_d;
   logic [bht_idx_width_p-1:0] w_idx_q, w_idx_d;
   logic                       w_correct_q, w_correct_d;

   logic                       fetch_acc;
   logic                       resolve_acc;
   logic                       unused_pc_bits;

   // PC bits outside the index window are not needed by the table
   assign unused_pc_bits = ^{fetch_pc_i[vaddr_width_p-1:pc_shift_p+bht_idx_width_p],
                             fetch_pc_i[pc_shift_p-1:0]};

   // Ready terms come from registered state only. A slot freed by this
   // cycle's resolve is therefore not visible to this cycle's fetch.
   assign fetch_ready_o   = (count_q < depth_lp);
   assign resolve_ready_o = (count_q != '0) & cap_q[head_q];

   assign fetch_acc   = fetch_v_i & fetch_ready_o;
   // a resolve arriving with a flush is dropped along with the queue
   assign resolve_acc = resolve_v_i & resolve_ready_o & ~flush_i;

   // predictor read happens in the accept cycle itself
   assign r_v_o   = fetch_acc;
   assign idx_r_o = fetch_pc_i[pc_shift_p+bht_idx_width_p-1:pc_shift_p];

   // prediction is forwarded straight from the predictor's read data
   assign pred_v_o     = pred_pend_q;
   assign pred_taken_o = pred_pend_q & predict_i;

   assign w_v_o     = w_v_q;
   assign idx_w_o   = w_idx_q;
   assign correct_o = w_correct_q;
   assign count_o   = count_q;

   // next-state for queue pointers, occupancy and entry storage
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      idx_mem_d  = idx_mem_q;
      pred_mem_d = pred_mem_q;
      cap_d      = cap_q;
      if (flush_i) begin
         // everything in flight is dropped, including a fetch accepted now
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         cap_d   = '0;
      end else begin
         // The capture slot is never the tail (depth >= 2) and never the
         // head being popped (that one is already captured).
         if (pred_pend_q) begin
            cap_d[pred_slot_q]      = 1'b1;
            pred_mem_d[pred_slot_q] = predict_i;
         end
         if (fetch_acc) begin
            idx_mem_d[tail_q] = idx_r_o;
            cap_d[tail_q]     = 1'b0;
            tail_d            = tail_q + ptr_w_lp'(1);
         end
         if (resolve_acc) begin
            cap_d[head_q] = 1'b0;
            head_d        = head_q + ptr_w_lp'(1);
         end
         count_d = count_q + cnt_w_lp'(fetch_acc) - cnt_w_lp'(resolve_acc);
      end
   end

   // next-state for the prediction return and the update pulse
   always_comb begin
      // a fetch accepted in a flush cycle never produces a prediction
      pred_pend_d = fetch_acc & ~flush_i;
      pred_slot_d = tail_q;
      // an update from an earlier resolve still goes out during a flush
      w_v_d       = resolve_acc;
      w_idx_d     = resolve_acc ? idx_mem_q[head_q] : '0;
      w_correct_d = resolve_acc & (pred_mem_q[head_q] == resolve_taken_i);
   end

   // queue state registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         pred_mem_q <= '0;
         cap_q      <= '0;
         for (int i = 0; i < queue_depth_p; i++) begin
            idx_mem_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         pred_mem_q <= pred_mem_d;
         cap_q      <= cap_d;
         idx_mem_q  <= idx_mem_d;
      end
   end

   // prediction and update pipeline registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pred_pend_q <= 1'b0;
         pred_slot_q <= '0;
         w_v_q       <= 1'b0;
         w_idx_q     <= '0;
         w_correct_q <= 1'b0;
      end else begin
         pred_pend_q <= pred_pend_d;
         pred_slot_q <= pred_slot_d;
         w_v_q       <= w_v_d;
         w_idx_q     <= w_idx_d;
         w_correct_q <= w_correct_d;
      end
   end

endmodule

// File: tb/tb_bp_fe_bp_bimodal_ctrl.sv
// Bench for the bimodal predictor controller. Updates are checked by a
// scoreboard that holds {due cycle, index, correct}. Each feature task also
// checks the handshake and occupancy outputs directly.
module tb_bp_fe_bp_bimodal_ctrl;

   localparam int VW = 39;
   localparam int IW = 9;
   localparam int D  = 4;
   localparam int EW = 32 + IW + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic          fetch_v_i = 1'b0;
   logic [VW-1:0] fetch_pc_i = '0;
   logic          fetch_ready_o;
   logic          pred_v_o, pred_taken_o;
   logic          resolve_v_i = 1'b0, resolve_taken_i = 1'b0;
   logic          resolve_ready_o;
   logic          flush_i = 1'b0;
   logic          r_v_o;
   logic [IW-1:0] idx_r_o;
   logic          predict_i = 1'b0;
   logic          w_v_o;
   logic [IW-1:0] idx_w_o;
   logic          correct_o;
   logic [2:0]    count_o;

   bp_fe_bp_bimodal_ctrl #(
      .vaddr_width_p(VW), .bht_idx_width_p(IW), .pc_shift_p(2), .queue_depth_p(D)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
      .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o),
      .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i),
      .resolve_ready_o(resolve_ready_o), .flush_i(flush_i),
      .r_v_o(r_v_o), .idx_r_o(idx_r_o), .predict_i(predict_i),
      .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
      .count_o(count_o)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q[$];

   // reference model of in-flight entries (index 0 = oldest)
   logic [IW-1:0] m_idx[$];
   logic          m_pred[$];
   logic          m_cap[$];
   logic          sched_v = 1'b0;
   logic          sched_val = 1'b0;
   int            m_cnt_pre;

   // outputs sampled at the negedge of the most recent driven cycle
   logic          obs_r_v, obs_fetch_ready, obs_pred_v, obs_pred_taken;
   logic          obs_resolve_ready, obs_w_v, obs_correct;
   logic [IW-1:0] obs_idx_r, obs_idx_w;
   logic [2:0]    obs_count;

   function automatic logic [VW-1:0] rnd_pc();
      return VW'({$urandom(), $urandom()});
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n) begin
         if (w_v_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected_update: got idx_w_o=%h correct_o=%b at cycle %0d, required no update",
                        idx_w_o, correct_o, cyc);
            end else begin
               e = exp_q.pop_front();
               if ({32'(cyc), idx_w_o, correct_o} !== e) begin
                  n_fail++;
                  $display("FAIL sb_update: got cycle=%0d idx=%h correct=%b, required cycle=%0d idx=%h correct=%b",
                           cyc, idx_w_o, correct_o, e[EW-1:IW+1], e[IW:1], e[0]);
               end
            end
         end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1:IW+1]) < cyc) begin
            n_checks++;
            n_fail++;
            e = exp_q.pop_front();
            $display("FAIL sb_missing_update: got no w_v_o at cycle %0d, required idx=%h correct=%b",
                     e[EW-1:IW+1], e[IW:1], e[0]);
         end
      end
   end

   // ---------------- driver ----------------
   // Drives one cycle of inputs, samples outputs at the negedge and
   // advances the reference model past the following rising edge.
   task automatic drive(input logic fv, input logic [VW-1:0] pc, input logic pbit,
                        input logic rv, input logic rt, input logic fl);
      logic m_acc, m_res;
      @(posedge clk);
      #1;
      fetch_v_i       = fv;
      fetch_pc_i      = pc;
      resolve_v_i     = rv;
      resolve_taken_i = rt;
      flush_i         = fl;
      predict_i       = sched_v ? sched_val : 1'($urandom_range(0, 1));
      @(negedge clk);
      obs_r_v           = r_v_o;
      obs_idx_r         = idx_r_o;
      obs_fetch_ready   = fetch_ready_o;
      obs_pred_v        = pred_v_o;
      obs_pred_taken    = pred_taken_o;
      obs_resolve_ready = resolve_ready_o;
      obs_count         = count_o;
      obs_w_v           = w_v_o;
      obs_idx_w         = idx_w_o;
      obs_correct       = correct_o;
      m_cnt_pre = m_idx.size();
      m_acc = fv && (m_idx.size() < D);
      m_res = rv && !fl && (m_idx.size() != 0) && m_cap[0];
      if (fl) begin
         m_idx.delete();
         m_pred.delete();
         m_cap.delete();
      end else begin
         if (sched_v) begin
            m_cap[m_cap.size()-1]   = 1'b1;
            m_pred[m_pred.size()-1] = sched_val;
         end
         if (m_res) begin
            exp_q.push_back({32'(cyc + 1), m_idx[0], (m_pred[0] == rt)});
            void'(m_idx.pop_front());
            void'(m_pred.pop_front());
            void'(m_cap.pop_front());
         end
         if (m_acc) begin
            m_idx.push_back(pc[IW+1:2]);
            m_pred.push_back(1'b0);
            m_cap.push_back(1'b0);
         end
      end
      sched_v   = m_acc && !fl;
      sched_val = pbit;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // resolve until the model is empty, bounded, then let the last update out
   task automatic drain();
      for (int i = 0; i < 16 && m_idx.size() != 0; i++) begin
         drive(1'b0, '0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end
      n_checks++;
      if (m_idx.size() != 0) begin
         n_fail++;
         $display("FAIL drain_bound: got %0d entries left, required 0", m_idx.size());
      end
      idle();
      idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", count_o); end
      n_checks++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %b, required 1", fetch_ready_o); end
      n_checks++; if (pred_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_pred_v: got %b, required 0", pred_v_o); end
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b, required 0", pred_taken_o); end
      n_checks++; if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_w_v: got %b, required 0", w_v_o); end
      n_checks++; if (idx_w_o !== 9'h000) begin n_fail++; $display("FAIL reset_idx_w: got %h, required 000", idx_w_o); end
      n_checks++; if (correct_o !== 1'b0) begin n_fail++; $display("FAIL reset_correct: got %b, required 0", correct_o); end
      n_checks++; if (resolve_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_resolve_ready: got %b, required 0", resolve_ready_o); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_fetch();
      drive(1'b1, 39'h1008, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (obs_r_v !== 1'b1) begin n_fail++; $display("FAIL single_r_v: got %b, required 1", obs_r_v); end
      n_checks++; if (obs_idx_r !== 9'h002) begin n_fail++; $display("FAIL single_idx_r: got %h, required 002", obs_idx_r); end
      idle();
      n_checks++; if (obs_pred_v !== 1'b1) begin n_fail++; $display("FAIL single_pred_v: got %b, required 1", obs_pred_v); end
      n_checks++; if (obs_pred_taken !== 1'b1) begin n_fail++; $display("FAIL single_pred_taken: got %b, required 1", obs_pred_taken); end
      n_checks++; if (obs_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d, required 1", obs_count); end
      n_checks++; if (obs_resolve_ready !== 1'b0) begin n_fail++; $display("FAIL single_not_ready_yet: got %b, required 0", obs_resolve_ready); end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++; if (obs_resolve_ready !== 1'b1) begin n_fail++; $display("FAIL single_resolve_ready: got %b, required 1", obs_resolve_ready); end
      idle();
      n_checks++; if (obs_w_v !== 1'b1) begin n_fail++; $display("FAIL single_w_v: got %b, required 1", obs_w_v); end
      n_checks++; if (obs_idx_w !== 9'h002) begin n_fail++; $display("FAIL single_idx_w: got %h, required 002", obs_idx_w); end
      n_checks++; if (obs_correct !== 1'b1) begin n_fail++; $display("FAIL single_correct: got %b, required 1", obs_correct); end
      n_checks++; if (obs_count !== 3'd0) begin n_fail++; $display("FAIL single_count_after: got %0d, required 0", obs_count); end
   endtask

   task automatic test_mispredict();
      drive(1'b1, 39'h2004, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (obs_idx_r !== 9'h001) begin n_fail++; $display("FAIL mispredict_idx_r: got %h, required 001", obs_idx_r); end
      idle();
      n_checks++; if (obs_pred_taken !== 1'b0) begin n_fail++; $display("FAIL mispredict_pred_taken: got %b, required 0", obs_pred_taken); end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle();
      n_checks++; if (obs_w_v !== 1'b1 || obs_correct !== 1'b0) begin
         n_fail++; $display("FAIL mispredict_correct: got w_v=%b correct=%b, required w_v=1 correct=0", obs_w_v, obs_correct);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < D; i++) begin
         drive(1'b1, rnd_pc(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         n_checks++; if (obs_r_v !== 1'b1) begin n_fail++; $display("FAIL full_fill_r_v[%0d]: got %b, required 1", i, obs_r_v); end
      end
      drive(1'b1, rnd_pc(), 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (obs_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d, required 4", obs_count); end
      n_checks++; if (obs_fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_fetch_ready: got %b, required 0", obs_fetch_ready); end
      n_checks++; if (obs_r_v !== 1'b0) begin n_fail++; $display("FAIL full_fifth_r_v: got %b, required 0", obs_r_v); end
      idle();
      n_checks++; if (obs_count !== 3'd4 || obs_pred_v !== 1'b0) begin
         n_fail++; $display("FAIL full_fifth_dropped: got count=%0d pred_v=%b, required count=4 pred_v=0", obs_count, obs_pred_v);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) drive(1'b1, rnd_pc(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      drive(1'b1, rnd_pc(), 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (obs_count !== 3'd3) begin n_fail++; $display("FAIL b2b_count_before: got %0d, required 3", obs_count); end
      n_checks++; if (obs_r_v !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b, required 1", obs_r_v); end
      idle();
      n_checks++; if (obs_count !== 3'd3) begin n_fail++; $display("FAIL b2b_count_after: got %0d, required 3", obs_count); end
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom_range(0, 1)), rnd_pc(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         n_checks++; if (int'(obs_count) != m_cnt_pre) begin
            n_fail++; $display("FAIL b2b_mixed_count[%0d]: got %0d, required %0d", i, obs_count, m_cnt_pre);
         end
      end
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) drive(1'b1, rnd_pc(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      drive(1'b1, rnd_pc(), 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      // flush cycle F: fetch, flush and a resolve all together
      drive(1'b1, rnd_pc(), 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++; if (obs_count !== 3'd3) begin n_fail++; $display("FAIL flush_count_at_f: got %0d, required 3", obs_count); end
      n_checks++; if (obs_pred_v !== 1'b1 || obs_pred_taken !== 1'b1) begin
         n_fail++; $display("FAIL flush_pred_at_f: got pred_v=%b taken=%b, required 1 1", obs_pred_v, obs_pred_taken);
      end
      n_checks++; if (obs_w_v !== 1'b1) begin n_fail++; $display("FAIL flush_w_at_f: got %b, required 1", obs_w_v); end
      n_checks++; if (obs_r_v !== 1'b1) begin n_fail++; $display("FAIL flush_accept_at_f: got %b, required 1", obs_r_v); end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++; if (obs_count !== 3'd0) begin n_fail++; $display("FAIL flush_count_f1: got %0d, required 0", obs_count); end
      n_checks++; if (obs_pred_v !== 1'b0) begin n_fail++; $display("FAIL flush_pred_v_f1: got %b, required 0", obs_pred_v); end
      n_checks++; if (obs_resolve_ready !== 1'b0) begin n_fail++; $display("FAIL flush_resolve_ready_f1: got %b, required 0", obs_resolve_ready); end
      idle();
      n_checks++; if (obs_w_v !== 1'b0 || obs_count !== 3'd0) begin
         n_fail++; $display("FAIL flush_quiet_f2: got w_v=%b count=%0d, required 0 0", obs_w_v, obs_count);
      end
   endtask

   task automatic test_resolve_guard();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++; if (obs_resolve_ready !== 1'b0) begin n_fail++; $display("FAIL guard_empty_ready: got %b, required 0", obs_resolve_ready); end
      drive(1'b1, rnd_pc(), 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++; if (obs_w_v !== 1'b0 || obs_count !== 3'd0) begin
         n_fail++; $display("FAIL guard_empty_effect: got w_v=%b count=%0d, required 0 0", obs_w_v, obs_count);
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (obs_resolve_ready !== 1'b0 || obs_count !== 3'd1) begin
         n_fail++; $display("FAIL guard_uncaptured: got ready=%b count=%0d, required 0 1", obs_resolve_ready, obs_count);
      end
      idle();
      n_checks++; if (obs_w_v !== 1'b0 || obs_count !== 3'd1 || obs_resolve_ready !== 1'b1) begin
         n_fail++; $display("FAIL guard_after: got w_v=%b count=%0d ready=%b, required 0 1 1", obs_w_v, obs_count, obs_resolve_ready);
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, rnd_pc(), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, rnd_pc(), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, rnd_pc(), 1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      n_checks++; if (w_v_o !== 1'b1 || pred_v_o !== 1'b1 || count_o !== 3'd2) begin
         n_fail++; $display("FAIL midreset_pre: got w_v=%b pred_v=%b count=%0d, required 1 1 2", w_v_o, pred_v_o, count_o);
      end
      fetch_v_i = 1'b0; resolve_v_i = 1'b0; flush_i = 1'b0; predict_i = 1'b1;
      rst_n = 1'b0;
      exp_q.delete();
      m_idx.delete(); m_pred.delete(); m_cap.delete();
      sched_v = 1'b0;
      #1;
      n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d, required 0", count_o); end
      n_checks++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_fetch_ready: got %b, required 1", fetch_ready_o); end
      n_checks++; if (pred_v_o !== 1'b0 || pred_taken_o !== 1'b0) begin
         n_fail++; $display("FAIL midreset_pred: got pred_v=%b taken=%b, required 0 0", pred_v_o, pred_taken_o);
      end
      n_checks++; if (w_v_o !== 1'b0 || idx_w_o !== 9'h000 || correct_o !== 1'b0) begin
         n_fail++; $display("FAIL midreset_update: got w_v=%b idx=%h correct=%b, required 0 000 0", w_v_o, idx_w_o, correct_o);
      end
      n_checks++; if (resolve_ready_o !== 1'b0) begin n_fail++; $display("FAIL midreset_resolve_ready: got %b, required 0", resolve_ready_o); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         n_checks++; if (obs_pred_v !== 1'b0 || obs_w_v !== 1'b0 || obs_count !== 3'd0) begin
            n_fail++; $display("FAIL midreset_quiet[%0d]: got pred_v=%b w_v=%b count=%0d, required 0 0 0", i, obs_pred_v, obs_w_v, obs_count);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_fetch();
      test_mispredict();
      test_full();
      test_back_to_back();
      test_flush();
      test_resolve_guard();
      test_reset_midstream();
      idle();
      idle();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending updates, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
